// File: rtl/minmax_scan.sv
// Scans an inclusive address window of a synchronous memory and reports min, max, range and word count.
// Optional first-address tracking of min/max is enabled by defining MINMAX_SCAN_ADDR_TRACK_EN.
module minmax_scan #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rd_valid,
    input  logic [DW-1:0] mem_rd_data,
    output logic          busy,
    output logic          done,
    output logic          empty,
    output logic [DW-1:0] min_val,
    output logic [DW-1:0] max_val,
    output logic [DW-1:0] max_diff,
    output logic [AW:0]   count
`ifdef MINMAX_SCAN_ADDR_TRACK_EN
    ,
    output logic [AW-1:0] min_addr,
    output logic [AW-1:0] max_addr
`endif
);

    // state | meaning
    // IDLE  | waiting for start; results of the last scan held
    // REQ   | one-cycle read request for address i
    // WAIT  | waiting for read data of address i
    // FIN   | compute max_diff, raise done next cycle
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] i_addr, j_addr;
    logic          first;

    assign mem_addr = i_addr;
    assign first    = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (start_addr > end_addr) ? FIN : REQ;
            end
            REQ: begin
                mem_rd_en = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rd_valid) state_nxt = (i_addr == j_addr) ? FIN : REQ;
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Equality termination keeps a window ending at the top address from wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_addr   <= '0;
            j_addr   <= '0;
            done     <= 1'b0;
            empty    <= 1'b0;
            min_val  <= '0;
            max_val  <= '0;
            max_diff <= '0;
            count    <= '0;
`ifdef MINMAX_SCAN_ADDR_TRACK_EN
            min_addr <= '0;
            max_addr <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i_addr   <= start_addr;
                        j_addr   <= end_addr;
                        empty    <= (start_addr > end_addr);
                        min_val  <= '0;
                        max_val  <= '0;
                        max_diff <= '0;
                        count    <= '0;
`ifdef MINMAX_SCAN_ADDR_TRACK_EN
                        min_addr <= '0;
                        max_addr <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_rd_valid) begin
                        if (first || (mem_rd_data < min_val)) begin
                            min_val <= mem_rd_data;
`ifdef MINMAX_SCAN_ADDR_TRACK_EN
                            min_addr <= i_addr;
`endif
                        end
                        if (first || (mem_rd_data > max_val)) begin
                            max_val <= mem_rd_data;
`ifdef MINMAX_SCAN_ADDR_TRACK_EN
                            max_addr <= i_addr;
`endif
                        end
                        count <= count + 1'b1;
                        if (i_addr != j_addr) i_addr <= i_addr + 1'b1;
                    end
                end
                FIN: begin
                    max_diff <= max_val - min_val;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
